bus_arbiter: RTL and testbench

- Shares the single system bus (32-bit data, 8-bit ctrl) between up to NUM_MASTERS requesters, e.g. the UART bridge, the CPU and DMA.
- Each master raises bus_req and holds it for its whole transaction. It drives the bus only after seeing its ack.
- The arbiter grants one master at a time in round-robin order and muxes the granted master's bus/ctrl onto the shared bus.
- A hold watchdog flags masters that keep the bus too long.

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arbiter_rr_sel.sv | 41 ++++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: FSM encodings and bus width defaults
// that the UART bridge also relies on.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int BUS_WIDTH_DEF  = 32;
  localparam int CTRL_WIDTH_DEF = 8;

  // Hold counter must be able to represent MAX_HOLD-1 and still saturate above it.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_sel.sv
// Rotating priority search: first set request bit at or after rr_ptr, wrapping at NUM_MASTERS.
module rr_priority_sel
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_WIDTH-1:0]    rr_ptr,
  output logic [ID_WIDTH-1:0]    sel,
  output logic                   any_req
);

  logic [ID_WIDTH-1:0] cand_idx [NUM_MASTERS];
  logic                found;

  // Candidate k is rr_ptr+k folded back into 0..NUM_MASTERS-1, so a non-power-of-two
  // master count never produces an index past the last master.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
      logic [ID_WIDTH:0] raw_sum;
      assign raw_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(gi);
      assign cand_idx[gi] = (raw_sum >= (ID_WIDTH+1)'(NUM_MASTERS))
                          ? ID_WIDTH'(raw_sum - (ID_WIDTH+1)'(NUM_MASTERS))
                          : raw_sum[ID_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[cand_idx[k]]) begin
        sel   = cand_idx[k];
        found = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus: one grant at a time, master-released,
// with a one-cycle turnaround and a sticky hold watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2,
  parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
  parameter int CTRL_WIDTH  = CTRL_WIDTH_DEF,
  parameter int MAX_HOLD    = 1024
) (
  input  logic                              clk50MHz,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            bus_req,
  output logic [NUM_MASTERS-1:0]            bus_ack,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_bus_in,
  input  logic [NUM_MASTERS*CTRL_WIDTH-1:0] m_ctrl_in,
  output logic [BUS_WIDTH-1:0]              bus_out,
  output logic [CTRL_WIDTH-1:0]             ctrl_out,
  output logic                              grant_valid,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              hold_timeout
);

  localparam int                     HOLD_W    = hold_cnt_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [NUM_MASTERS-1:0] ACK_ONE   = NUM_MASTERS'(1);
  localparam logic [ID_WIDTH-1:0]    LAST_ID   = ID_WIDTH'(NUM_MASTERS - 1);

  arb_state_t          state_reg;
  logic [ID_WIDTH-1:0] rr_ptr_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [ID_WIDTH-1:0] sel;
  logic                any_req;

  rr_priority_sel #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_WIDTH    (ID_WIDTH)
  ) u_rr_sel (
    .req     (bus_req),
    .rr_ptr  (rr_ptr_reg),
    .sel     (sel),
    .any_req (any_req)
  );

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      bus_ack      <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
      hold_timeout <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (any_req) begin
            bus_ack      <= ACK_ONE << sel;
            grant_id     <= sel;
            grant_valid  <= 1'b1;
            hold_cnt_reg <= '0;
            state_reg    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (bus_req[grant_id]) begin
            if (hold_cnt_reg != '1)
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end else begin
            bus_ack     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            // The master just served drops to lowest priority next round.
            rr_ptr_reg  <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            state_reg   <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          state_reg <= ARB_IDLE;
        end
        default: begin
          state_reg <= ARB_IDLE;
        end
      endcase

      // Flag only; the grant is never taken away from the master.
      if (MAX_HOLD > 0 && state_reg == ARB_GRANT && hold_cnt_reg == HOLD_LAST)
        hold_timeout <= 1'b1;
    end
  end

  logic [BUS_WIDTH-1:0]  bus_slice  [NUM_MASTERS];
  logic [CTRL_WIDTH-1:0] ctrl_slice [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
      assign bus_slice[gi]  = m_bus_in[gi*BUS_WIDTH +: BUS_WIDTH];
      assign ctrl_slice[gi] = m_ctrl_in[gi*CTRL_WIDTH +: CTRL_WIDTH];
    end
  endgenerate

  always_comb begin
    bus_out  = '0;
    ctrl_out = '0;
    if (grant_valid) begin
      bus_out  = bus_slice[grant_id];
      ctrl_out = ctrl_slice[grant_id];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a 4-master instance with a short watchdog and a
// 3-master instance for the non-power-of-two wrap.
module tb_bus_arbiter;

  logic clk50MHz = 1'b0;
  logic rst;

  logic [3:0]   req4, ack4;
  logic [127:0] mbus4;
  logic [31:0]  mctrl4, bus4;
  logic [7:0]   ctrl4;
  logic         gv4, to4;
  logic [1:0]   gid4;

  logic [2:0]   req3, ack3;
  logic [95:0]  mbus3;
  logic [23:0]  mctrl3;
  logic [31:0]  bus3;
  logic [7:0]   ctrl3;
  logic         gv3, to3;
  logic [1:0]   gid3;

  always #10 clk50MHz = ~clk50MHz;

  bus_arbiter #(
    .NUM_MASTERS(4), .ID_WIDTH(2), .BUS_WIDTH(32), .CTRL_WIDTH(8), .MAX_HOLD(8)
  ) dut4 (
    .clk50MHz(clk50MHz), .rst(rst), .bus_req(req4), .bus_ack(ack4),
    .m_bus_in(mbus4), .m_ctrl_in(mctrl4), .bus_out(bus4), .ctrl_out(ctrl4),
    .grant_valid(gv4), .grant_id(gid4), .hold_timeout(to4)
  );

  bus_arbiter #(
    .NUM_MASTERS(3), .ID_WIDTH(2), .BUS_WIDTH(32), .CTRL_WIDTH(8), .MAX_HOLD(0)
  ) dut3 (
    .clk50MHz(clk50MHz), .rst(rst), .bus_req(req3), .bus_ack(ack3),
    .m_bus_in(mbus3), .m_ctrl_in(mctrl3), .bus_out(bus3), .ctrl_out(ctrl3),
    .grant_valid(gv3), .grant_id(gid3), .hold_timeout(to3)
  );

  localparam int S_ACK4 = 0, S_GV4 = 1, S_GID4 = 2, S_BUS4 = 3, S_CTRL4 = 4, S_TO4 = 5;
  localparam int S_ACK3 = 6, S_GV3 = 7, S_GID3 = 8, S_BUS3 = 9, S_TO3 = 10;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] bench_bus4  [4];
  logic [7:0]  bench_ctrl4 [4];
  logic [31:0] bench_bus3  [3];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_ACK4:  return 32'(ack4);
      S_GV4:   return 32'(gv4);
      S_GID4:  return 32'(gid4);
      S_BUS4:  return bus4;
      S_CTRL4: return 32'(ctrl4);
      S_TO4:   return 32'(to4);
      S_ACK3:  return 32'(ack3);
      S_GV3:   return 32'(gv3);
      S_GID3:  return 32'(gid3);
      S_BUS3:  return bus3;
      S_TO3:   return 32'(to3);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // One clock: expectations queued before the edge are compared 1 ns after it.
  task automatic step();
    exp_t e;
    @(posedge clk50MHz);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
    $display("t=%0t req4=%b ack4=%b gid4=%0d to4=%b | req3=%b ack3=%b gid3=%0d",
             $time, req4, ack4, gid4, to4, req3, ack3, gid3);
  endtask

  task automatic expect_grant4(input string tag, input int m);
    expect_val({tag, "_ack"},  S_ACK4,  32'd1 << m);
    expect_val({tag, "_gv"},   S_GV4,   32'd1);
    expect_val({tag, "_gid"},  S_GID4,  32'(m));
    expect_val({tag, "_bus"},  S_BUS4,  bench_bus4[m]);
    expect_val({tag, "_ctrl"}, S_CTRL4, 32'(bench_ctrl4[m]));
  endtask

  task automatic expect_idle4(input string tag);
    expect_val({tag, "_ack"},  S_ACK4,  32'd0);
    expect_val({tag, "_gv"},   S_GV4,   32'd0);
    expect_val({tag, "_gid"},  S_GID4,  32'd0);
    expect_val({tag, "_bus"},  S_BUS4,  32'd0);
    expect_val({tag, "_ctrl"}, S_CTRL4, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst  = 1'b1;
    req4 = '0;
    req3 = '0;
    expect_idle4(tag);
    expect_val({tag, "_to4"},  S_TO4,  32'd0);
    expect_val({tag, "_ack3"}, S_ACK3, 32'd0);
    expect_val({tag, "_gv3"},  S_GV3,  32'd0);
    expect_val({tag, "_to3"},  S_TO3,  32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int order [5];
    int m;
    order = '{0, 1, 2, 3, 0};
    bench_bus4  = '{32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    bench_ctrl4 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    bench_bus3  = '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002};
    for (int i = 0; i < 4; i++) begin
      mbus4[i*32 +: 32] = bench_bus4[i];
      mctrl4[i*8 +: 8]  = bench_ctrl4[i];
    end
    for (int i = 0; i < 3; i++) begin
      mbus3[i*32 +: 32] = bench_bus3[i];
      mctrl3[i*8 +: 8]  = 8'hC0 + 8'(i);
    end
    rst  = 1'b1;
    req4 = '0;
    req3 = '0;
    step();
    do_reset("reset");

    // Single request: ack one cycle later, mux shows master 0.
    req4 = 4'b0001;
    expect_grant4("single", 0);
    step();
    req4 = 4'b0000;
    expect_idle4("single_drop");
    step();
    step();

    // Masters 0 and 2 together from reset; RELEASE gap, then master 2.
    do_reset("reset2");
    req4 = 4'b0101;
    expect_grant4("pair_first", 0);
    step();
    expect_grant4("pair_hold", 0);
    step();
    req4 = 4'b0100;
    expect_idle4("pair_release");
    step();
    expect_val("pair_idle_ack", S_ACK4, 32'd0);
    step();
    expect_grant4("pair_second", 2);
    step();
    req4 = 4'b0000;
    expect_idle4("pair_drop");
    step();
    step();

    // All four hold requests; round-robin order 0,1,2,3,0.
    do_reset("reset3");
    req4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      m = order[i];
      expect_grant4($sformatf("rr%0d_grant", i), m);
      step();
      for (int c = 0; c < 4; c++) begin
        expect_val($sformatf("rr%0d_hold%0d", i, c), S_ACK4, 32'd1 << m);
        step();
      end
      req4[m] = 1'b0;
      expect_idle4($sformatf("rr%0d_release", i));
      step();
      req4[m] = 1'b1;
      expect_val($sformatf("rr%0d_idle", i), S_ACK4, 32'd0);
      step();
    end
    req4 = '0;
    step();

    // Watchdog: master 1 holds 20 cycles, timeout after 8 grant cycles, sticky.
    do_reset("reset4");
    req4 = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      expect_val($sformatf("wd%0d_ack", k), S_ACK4, 32'b0010);
      expect_val($sformatf("wd%0d_to", k), S_TO4, (k >= 8) ? 32'd1 : 32'd0);
      step();
    end
    req4 = '0;
    expect_val("wd_release_ack", S_ACK4, 32'd0);
    expect_val("wd_release_to", S_TO4, 32'd1);
    step();
    expect_val("wd_sticky_to", S_TO4, 32'd1);
    step();
    step();

    // Reset mid-grant of master 3, then rr_ptr back at 0.
    do_reset("reset5");
    req4 = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      expect_val($sformatf("mid%0d_gid", k), S_GID4, 32'd3);
      step();
    end
    expect_val("mid_pre_to", S_TO4, 32'd1);
    step();
    rst = 1'b1;
    expect_idle4("mid_rst");
    expect_val("mid_rst_to", S_TO4, 32'd0);
    step();
    rst  = 1'b0;
    req4 = 4'b1001;
    expect_grant4("post_rst", 0);
    step();
    req4 = '0;
    step();
    step();
    step();

    // Three masters: pointer wraps from 2 to 0.
    do_reset("reset6");
    req3 = 3'b100;
    expect_val("n3_g2_ack", S_ACK3, 32'b100);
    expect_val("n3_g2_gid", S_GID3, 32'd2);
    expect_val("n3_g2_bus", S_BUS3, bench_bus3[2]);
    step();
    req3 = 3'b011;
    expect_val("n3_rel_ack", S_ACK3, 32'd0);
    expect_val("n3_rel_gv", S_GV3, 32'd0);
    step();
    expect_val("n3_idle_ack", S_ACK3, 32'd0);
    step();
    expect_val("n3_wrap_ack", S_ACK3, 32'b001);
    expect_val("n3_wrap_gid", S_GID3, 32'd0);
    expect_val("n3_wrap_bus", S_BUS3, bench_bus3[0]);
    step();
    req3 = 3'b010;
    expect_val("n3_rel2_ack", S_ACK3, 32'd0);
    step();
    step();
    expect_val("n3_g1_ack", S_ACK3, 32'b010);
    expect_val("n3_g1_gid", S_GID3, 32'd1);
    step();
    req3 = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
